thread_scheduler: RTL
=====================

// Module: thread_scheduler
// PURPOSE
//  Sequences NUM_THREADS WalkSAT solver-thread controllers from one host stream.
//  Each cycle, it routes one host load beat (ATT, CT or UCB) to a masked subset of threads.
//  It then pulses start, releases start_run and collects done/unsat counts.
//  It reports the first SAT thread (lowest index on ties), all-exhausted UNSAT, or watchdog TIMEOUT.
// PARAMETERS
//  NUM_THREADS     4          solver threads driven
//  LOAD_ADDR_W     13         shared load address width (>= widest of ATT/CT/UCB address)
//  LOAD_DATA_W     256        shared load data width (>= widest of ATT/CT/UCB data)
//  UCNT_W          11         per-thread unsat-buffer count width
//  WATCHDOG_CYCLES 32'h0FFF_FFFF  RUN-phase cycle limit before TIMEOUT
// PORTS
//  clk              in   1                  clock, all state on rising edge
//  rst_n            in   1                  async active-low reset
//  host_start_i     in   1                  1-cycle pulse: begin a new job (ignored unless IDLE/REPORT)
//  host_valid_i     in   1                  load beat valid
//  host_ready_o     out  1                  load beat ready (high only in LOAD)
//  host_type_i      in   2                  0=ATT 1=CT 2=UCB 3=reserved (beat accepted, dropped)
//  host_mask_i      in   NUM_THREADS        target threads for this beat
//  host_addr_i      in   LOAD_ADDR_W        beat address
//  host_data_i      in   LOAD_DATA_W        beat data
//  host_last_i      in   1                  final beat of job (qualified by valid&ready)
//  thr_start_o      out  NUM_THREADS        per-thread start pulse
//  thr_start_run_o  out  NUM_THREADS        per-thread start_run level
//  thr_att_valid_o  out  NUM_THREADS        per-thread ATT load valid
//  thr_ct_valid_o   out  NUM_THREADS        per-thread CT load valid
//  thr_ucb_valid_o  out  NUM_THREADS        per-thread UCB load valid
//  thr_addr_o       out  LOAD_ADDR_W        shared load address (all threads)
//  thr_data_o       out  LOAD_DATA_W        shared load data (all threads)
//  thr_load_done_i  in   NUM_THREADS        thread finished LOAD
//  thr_done_i       in   NUM_THREADS        thread in DONE
//  thr_ucnt_i       in   NUM_THREADS*UCNT_W unsat counts; thread k at [k*UCNT_W +: UCNT_W]
//  busy_o           out  1                  state != IDLE and != REPORT
//  result_valid_o   out  1                  high throughout REPORT
//  status_o         out  2                  0=NONE 1=SAT 2=UNSAT 3=TIMEOUT; held in REPORT
//  winner_o         out  $clog2(NUM_THREADS) SAT thread index; 0 unless status=SAT
//  run_cycles_o     out  32                 RUN-phase cycle count; saturates at all-ones
// BEHAVIOUR
//  Reset (rst_n low, async): state IDLE; all outputs 0; counters 0. Takes effect mid-job too.
//  IDLE -> ARM on host_start_i.
//  ARM (1 cycle): thr_start_o = all ones -> LOAD.
//  LOAD: host_ready_o = 1. An accepted beat is registered and appears on thr_* one cycle later.
//    The valid bit for host_type_i is set for threads in host_mask_i; the other valids are 0.
//    Without an accepted beat, all valids are 0 the next cycle.
//    Accepted beat with host_last_i -> DRAIN.
//  DRAIN (1 cycle): forwards the last beat; host_ready_o = 0 -> RUN.
//  RUN: thr_start_run_o = all ones, held until every thread_load_done_i is high.
//    run_cycles_o increments each cycle. Per-thread sat[k] = thr_done_i[k] & (ucnt_k == 0).
//    Priority order, evaluated each cycle:
//      any sat -> REPORT, status SAT, winner = lowest k;
//      all thr_done_i, none sat -> REPORT, status UNSAT;
//      run_cycles_o == WATCHDOG_CYCLES-1 -> REPORT, status TIMEOUT.
//    SAT beats TIMEOUT when both occur in the same cycle.
//  REPORT: result_valid_o = 1; status, winner and run_cycles are frozen.
//    host_start_i -> ARM and clears result/counters in that transition.
//    Threads in DONE accept start directly.
//  host_start_i outside IDLE/REPORT: ignored. host_valid_i outside LOAD: not accepted.
//  A zero-beat job is illegal. host_mask_i == 0 gives an accepted beat with all valids 0.
// STRUCTURE
//  Shared package sat_sched_pkg: state encoding (IDLE, ARM, LOAD, DRAIN, RUN, REPORT),
//    beat-type codes, status codes.
//  Sub-module sat_winner_pe: parameterised lowest-index priority encoder (any, idx).
//  Datapath: registered beat stage, 32-bit saturating cycle counter.
// TESTING
//  1. Reset mid-LOAD -> next cycle all outputs 0, host_ready_o=0, state IDLE.
//  2. N=4; start; 3 beats ATT/CT/UCB mask 4'b0101, last on beat 3
//     -> each beat on thr_* one cycle after accept, valids only on threads 0 and 2;
//     start_run asserted 2 cycles after the last accept.
//  3. RUN; threads 1 and 3 raise done with ucnt=0 in the same cycle
//     -> status=1, winner=1, result_valid next cycle.
//  4. All 4 done, ucnt=5 each -> status=2, winner=0.
//  5. WATCHDOG_CYCLES=16, no done -> status=3 after 16 RUN cycles, run_cycles_o=15.
//  6. From REPORT, host_start_i -> thr_start_o=4'b1111 for 1 cycle, result cleared;
//     host_start_i during RUN ignored.

Source files
------------

// File: rtl/sat_sched_pkg.sv
// Shared encodings for the WalkSAT thread scheduler: FSM states, host beat types
// and report status codes.
package sat_sched_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_ARM    = 3'd1;
    localparam logic [2:0] ST_LOAD   = 3'd2;
    localparam logic [2:0] ST_DRAIN  = 3'd3;
    localparam logic [2:0] ST_RUN    = 3'd4;
    localparam logic [2:0] ST_REPORT = 3'd5;

    localparam logic [1:0] BEAT_ATT  = 2'd0;
    localparam logic [1:0] BEAT_CT   = 2'd1;
    localparam logic [1:0] BEAT_UCB  = 2'd2;
    localparam logic [1:0] BEAT_RSVD = 2'd3;

    localparam logic [1:0] STAT_NONE    = 2'd0;
    localparam logic [1:0] STAT_SAT     = 2'd1;
    localparam logic [1:0] STAT_UNSAT   = 2'd2;
    localparam logic [1:0] STAT_TIMEOUT = 2'd3;

endpackage

// File: rtl/sat_winner_pe.sv
// Lowest-index priority encoder: picks the first satisfied thread when several
// report SAT in the same cycle.
module sat_winner_pe #(
    parameter int N = 4,
    localparam int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req,
    output logic         any,
    output logic [W-1:0] idx
);

    assign any = |req;

    // Scan from the top so the lowest set bit is the last one written.
    always_comb begin
        idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[k]) idx = W'(k);
        end
    end

endmodule

// File: rtl/thread_scheduler.sv
// Sequences NUM_THREADS WalkSAT solver threads from one host load stream and
// reports the first SAT thread, all-exhausted UNSAT, or a watchdog TIMEOUT.
module thread_scheduler
    import sat_sched_pkg::*;
#(
    parameter int          NUM_THREADS     = 4,
    parameter int          LOAD_ADDR_W     = 13,
    parameter int          LOAD_DATA_W     = 256,
    parameter int          UCNT_W          = 11,
    parameter logic [31:0] WATCHDOG_CYCLES = 32'h0FFF_FFFF,
    localparam int         WIN_W           = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          host_start_i,
    input  logic                          host_valid_i,
    output logic                          host_ready_o,
    input  logic [1:0]                    host_type_i,
    input  logic [NUM_THREADS-1:0]        host_mask_i,
    input  logic [LOAD_ADDR_W-1:0]        host_addr_i,
    input  logic [LOAD_DATA_W-1:0]        host_data_i,
    input  logic                          host_last_i,
    output logic [NUM_THREADS-1:0]        thr_start_o,
    output logic [NUM_THREADS-1:0]        thr_start_run_o,
    output logic [NUM_THREADS-1:0]        thr_att_valid_o,
    output logic [NUM_THREADS-1:0]        thr_ct_valid_o,
    output logic [NUM_THREADS-1:0]        thr_ucb_valid_o,
    output logic [LOAD_ADDR_W-1:0]        thr_addr_o,
    output logic [LOAD_DATA_W-1:0]        thr_data_o,
    input  logic [NUM_THREADS-1:0]        thr_load_done_i,
    input  logic [NUM_THREADS-1:0]        thr_done_i,
    input  logic [NUM_THREADS*UCNT_W-1:0] thr_ucnt_i,
    output logic                          busy_o,
    output logic                          result_valid_o,
    output logic [1:0]                    status_o,
    output logic [WIN_W-1:0]              winner_o,
    output logic [31:0]                   run_cycles_o,
    output logic [2:0]                    dbg_state_o
);

    // Host beat handshake: a beat transfers on a rising edge where host_valid_i
    // and host_ready_o are both high; ready is a pure function of state (LOAD),
    // so it never depends on valid combinationally.
    logic [2:0]             state, state_nxt;
    logic                   accept;
    logic                   loads_seen;
    logic [NUM_THREADS-1:0] sat_vec;
    logic                   any_sat;
    logic [WIN_W-1:0]       win_idx;
    logic                   all_done;
    logic                   watchdog_hit;

    assign host_ready_o    = (state == ST_LOAD);
    assign accept          = host_valid_i & host_ready_o;
    assign thr_start_o     = {NUM_THREADS{state == ST_ARM}};
    assign thr_start_run_o = {NUM_THREADS{(state == ST_RUN) && !loads_seen}};
    assign busy_o          = (state != ST_IDLE) && (state != ST_REPORT);
    assign result_valid_o  = (state == ST_REPORT);
    assign dbg_state_o     = state;
    assign all_done        = &thr_done_i;
    assign watchdog_hit    = (run_cycles_o == WATCHDOG_CYCLES - 32'd1);

    always_comb begin
        sat_vec = '0;
        for (int k = 0; k < NUM_THREADS; k++) begin
            sat_vec[k] = thr_done_i[k] && (thr_ucnt_i[k*UCNT_W +: UCNT_W] == '0);
        end
    end

    sat_winner_pe #(.N(NUM_THREADS)) u_winner_pe (
        .req (sat_vec),
        .any (any_sat),
        .idx (win_idx)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (host_start_i) state_nxt = ST_ARM;
            ST_ARM:    state_nxt = ST_LOAD;
            ST_LOAD:   if (accept && host_last_i) state_nxt = ST_DRAIN;
            ST_DRAIN:  state_nxt = ST_RUN;
            ST_RUN:    if (any_sat || all_done || watchdog_hit) state_nxt = ST_REPORT;
            ST_REPORT: if (host_start_i) state_nxt = ST_ARM;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= ST_IDLE;
            loads_seen      <= 1'b0;
            thr_att_valid_o <= '0;
            thr_ct_valid_o  <= '0;
            thr_ucb_valid_o <= '0;
            thr_addr_o      <= '0;
            thr_data_o      <= '0;
            status_o        <= STAT_NONE;
            winner_o        <= '0;
            run_cycles_o    <= '0;
        end else begin
            state <= state_nxt;

            if (accept) begin
                thr_att_valid_o <= (host_type_i == BEAT_ATT) ? host_mask_i : '0;
                thr_ct_valid_o  <= (host_type_i == BEAT_CT)  ? host_mask_i : '0;
                thr_ucb_valid_o <= (host_type_i == BEAT_UCB) ? host_mask_i : '0;
                thr_addr_o      <= host_addr_i;
                thr_data_o      <= host_data_i;
            end else begin
                thr_att_valid_o <= '0;
                thr_ct_valid_o  <= '0;
                thr_ucb_valid_o <= '0;
            end

            // The exit cycle does not count, so a timeout freezes at WATCHDOG_CYCLES-1.
            if (state_nxt == ST_ARM) begin
                status_o     <= STAT_NONE;
                winner_o     <= '0;
                run_cycles_o <= '0;
                loads_seen   <= 1'b0;
            end else if (state == ST_RUN) begin
                if (&thr_load_done_i) loads_seen <= 1'b1;
                if (state_nxt == ST_REPORT) begin
                    if (any_sat) begin
                        status_o <= STAT_SAT;
                        winner_o <= win_idx;
                    end else if (all_done) begin
                        status_o <= STAT_UNSAT;
                    end else begin
                        status_o <= STAT_TIMEOUT;
                    end
                end else if (run_cycles_o != '1) begin
                    run_cycles_o <= run_cycles_o + 32'd1;
                end
            end
        end
    end

endmodule
